// File: rtl/a5_pkg.sv
// Shared definitions for the A5/1 Wishbone sequencer: register map and FSM states.
package a5_pkg;

  localparam logic [31:0] A5_REG_ID     = 32'h0000_0000;
  localparam logic [31:0] A5_REG_LOAD   = 32'h0000_0004;
  localparam logic [31:0] A5_REG_KEY_LO = 32'h0000_0010;
  localparam logic [31:0] A5_REG_KEY_HI = 32'h0000_0014;
  localparam logic [31:0] A5_REG_FRAME  = 32'h0000_0018;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KLO,
    ST_WR_KHI,
    ST_WR_FRM,
    ST_LOAD,
    ST_WAIT,
    ST_RD,
    ST_PUSH,
    ST_GAP,
    ST_FIN
  } a5_state_e;

endpackage

// File: rtl/a5_wb_access.sv
// Single-access Wishbone classic engine: owns cyc/stb, the latched access
// fields and the ack timeout counter. A request is taken only while idle.
module a5_wb_access #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_timeout,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [3:0]  o_sel,
  output logic [31:0] o_adr,
  output logic [31:0] o_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic          r_active;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic [TW-1:0] r_tmo;

  // Ack and timeout are combinational so cyc/stb drop and the caller moves on
  // in the same following cycle; an ack on the last allowed cycle wins.
  assign o_ack     = r_active & i_wb_ack;
  assign o_timeout = r_active & ~i_wb_ack & (r_tmo == TW'(ACK_TIMEOUT - 1));
  assign o_rdata   = i_wb_dat;

  assign o_cyc = r_active;
  assign o_stb = r_active;
  assign o_we  = r_we;
  assign o_sel = r_sel;
  assign o_adr = r_adr;
  assign o_dat = r_dat;

  // Access launch, hold until ack/timeout, then return bus signals to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_tmo    <= '0;
    end else if (!r_active) begin
      if (i_req) begin
        r_active <= 1'b1;
        r_we     <= i_we;
        r_sel    <= '1;
        r_adr    <= i_adr;
        r_dat    <= i_dat;
        r_tmo    <= '0;
      end
    end else if (o_ack || o_timeout) begin
      r_active <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_tmo    <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

endmodule

// File: rtl/a5_wb_sequencer.sv
// Wishbone master that configures the A5/1 peripheral (key, frame, load) and
// then streams NUM keystream words out on a valid/ready interface.
module a5_wb_sequencer
  import a5_pkg::*;
#(
  parameter int unsigned LOAD_WAIT   = 128,
  parameter int unsigned READ_GAP    = 32,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      key,
  input  logic [21:0]      frame,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  localparam int unsigned WAIT_MAX = (LOAD_WAIT > READ_GAP) ? LOAD_WAIT : READ_GAP;
  localparam int unsigned CW       = $clog2(WAIT_MAX + 2);

  a5_state_e        r_state;
  a5_state_e        w_next;
  logic [63:0]      r_key;
  logic [21:0]      r_frame;
  logic [CNT_W-1:0] r_remaining;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_ks_data;
  logic             r_ks_valid;
  logic             r_error;

  logic             w_req;
  logic             w_we;
  logic [31:0]      w_adr;
  logic [31:0]      w_dat;
  logic             w_ack;
  logic             w_timeout;
  logic [31:0]      w_rdata;
  logic [31:0]      w_cnt_ext;
  logic             w_wait_done;
  logic             w_gap_done;

  a5_wb_access #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_access (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_req),
    .i_we     (w_we),
    .i_adr    (w_adr),
    .i_dat    (w_dat),
    .o_ack    (w_ack),
    .o_rdata  (w_rdata),
    .o_timeout(w_timeout),
    .o_cyc    (wbm_cyc_o),
    .o_stb    (wbm_stb_o),
    .o_we     (wbm_we_o),
    .o_sel    (wbm_sel_o),
    .o_adr    (wbm_adr_o),
    .o_dat    (wbm_dat_o),
    .i_wb_ack (wbm_ack_i),
    .i_wb_dat (wbm_dat_i)
  );

  assign w_cnt_ext   = 32'(r_cnt);
  assign w_wait_done = (w_cnt_ext + 32'd1) >= LOAD_WAIT;
  assign w_gap_done  = (w_cnt_ext + 32'd1) >= READ_GAP;

  assign busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done     = (r_state == ST_FIN);
  assign error    = r_error;
  assign ks_data  = r_ks_data;
  assign ks_valid = r_ks_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and access request. The engine ignores requests while busy, so
  // holding req through the ack cycle cannot launch a duplicate; the state has
  // already moved on by the time the engine is idle again, which also yields
  // the mandatory idle cycle between strobes.
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_we   = 1'b0;
    w_adr  = '0;
    w_dat  = '0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_WR_KLO;
      ST_WR_KLO: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = A5_REG_KEY_LO; w_dat = r_key[31:0];
        if (w_ack) w_next = ST_WR_KHI;
      end
      ST_WR_KHI: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = A5_REG_KEY_HI; w_dat = r_key[63:32];
        if (w_ack) w_next = ST_WR_FRM;
      end
      ST_WR_FRM: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = A5_REG_FRAME; w_dat = {10'b0, r_frame};
        if (w_ack) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_req = 1'b1; w_adr = A5_REG_LOAD;
        if (w_ack) w_next = ST_WAIT;
      end
      ST_WAIT:   if (w_wait_done) w_next = (r_remaining == '0) ? ST_FIN : ST_RD;
      ST_RD: begin
        w_req = 1'b1; w_adr = A5_REG_ID;
        if (w_ack) w_next = ST_PUSH;
      end
      ST_PUSH:   if (ks_ready) w_next = (r_remaining != '0) ? ST_GAP : ST_FIN;
      ST_GAP:    if (w_gap_done) w_next = ST_RD;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  // Captured job parameters, wait counter, keystream output and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key       <= '0;
      r_frame     <= '0;
      r_remaining <= '0;
      r_cnt       <= '0;
      r_ks_data   <= '0;
      r_ks_valid  <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if (r_state == ST_IDLE && start) begin
        r_key       <= key;
        r_frame     <= frame;
        r_remaining <= num_words;
      end
      if ((r_state == ST_WAIT || r_state == ST_GAP) && (w_next == r_state))
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;
      if (r_state == ST_RD && w_ack) begin
        r_ks_data   <= w_rdata;
        r_ks_valid  <= 1'b1;
        r_remaining <= r_remaining - CNT_W'(1);
      end else if ((r_state == ST_PUSH && ks_ready) || w_timeout) begin
        r_ks_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_a5_wb_sequencer.sv
module tb_a5_wb_sequencer;
  import a5_pkg::*;

  localparam int unsigned LOAD_WAIT   = 128;
  localparam int unsigned READ_GAP    = 32;
  localparam int unsigned ACK_TIMEOUT = 15;
  localparam int unsigned CNT_W       = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [63:0]      key = '0;
  logic [21:0]      frame = '0;
  logic [CNT_W-1:0] num_words = '0;
  logic             busy, done, error;
  logic [31:0]      ks_data;
  logic             ks_valid;
  logic             ks_ready = 1'b1;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o;
  logic             wbm_ack_i = 1'b0;
  logic [31:0]      wbm_dat_i = '0;

  a5_wb_sequencer #(
    .LOAD_WAIT(LOAD_WAIT), .READ_GAP(READ_GAP), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .frame(frame),
    .num_words(num_words), .busy(busy), .done(done), .error(error),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] ks_q[$];
  logic [31:0] rd_words[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: one wait cycle, then ack; acks only when ack was low.
  int unsigned s_wait = 0;
  logic        s_block = 1'b0;
  logic [31:0] s_block_adr = '0;
  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
      if (s_wait >= 1 && !(s_block && wbm_adr_o == s_block_adr)) begin
        wbm_ack_i <= 1'b1;
        s_wait    <= 0;
        if (!wbm_we_o && wbm_adr_o == A5_REG_ID)
          wbm_dat_i <= (rd_words.size() > 0) ? rd_words.pop_front() : 32'h0;
        else
          wbm_dat_i <= 32'hDEADBEEF;
      end else begin
        s_wait <= s_wait + 1;
      end
    end else begin
      wbm_ack_i <= 1'b0;
      s_wait    <= 0;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  int   cyc_n = 0;
  int   done_cnt = 0, err_cnt = 0, acc_cnt = 0, rd_cnt = 0, beats = 0;
  int   last_ack_cyc = -100, last_rd_rise = -1, first_rd_rise = -1;
  int   last_stb_rise = 0, load_ack_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic prev_stb = 1'b0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (wbm_stb_o && !prev_stb) begin
        last_stb_rise = cyc_n;
        check("idle_between_accesses", 64'(cyc_n - last_ack_cyc >= 2), 1);
        if (!wbm_we_o && wbm_adr_o == A5_REG_ID) begin
          if (last_rd_rise >= 0)
            check("read_spacing", 64'(cyc_n - last_rd_rise >= int'(READ_GAP)), 1);
          else
            first_rd_rise = cyc_n;
          last_rd_rise = cyc_n;
        end
      end
      if (wbm_cyc_o && wbm_stb_o) check("sel", 64'(wbm_sel_o), 64'hF);
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        bus_t e;
        acc_cnt++;
        last_ack_cyc = cyc_n;
        if (!wbm_we_o && wbm_adr_o == A5_REG_LOAD) load_ack_cyc = cyc_n;
        if (!wbm_we_o && wbm_adr_o == A5_REG_ID) rd_cnt++;
        check("access_expected", 64'(bus_q.size() != 0), 1);
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          check("bus_we", 64'(wbm_we_o), 64'(e.we));
          check("bus_adr", 64'(wbm_adr_o), 64'(e.adr));
          if (e.we) check("bus_dat", 64'(wbm_dat_o), 64'(e.dat));
        end
      end
      if (ks_valid && ks_ready) begin
        beats++;
        check("ks_expected", 64'(ks_q.size() != 0), 1);
        if (ks_q.size() != 0) check("ks_data", 64'(ks_data), 64'(ks_q.pop_front()));
      end
      if (done) begin done_cnt++; done_cyc = cyc_n; end
      if (error) begin err_cnt++; err_cyc = cyc_n; end
    end
    prev_stb = wbm_stb_o;
  end

  task automatic push_seq(input logic [63:0] k, input logic [21:0] f, input int n);
    bus_t e;
    e.we = 1'b1; e.adr = A5_REG_KEY_LO; e.dat = k[31:0];      bus_q.push_back(e);
    e.we = 1'b1; e.adr = A5_REG_KEY_HI; e.dat = k[63:32];     bus_q.push_back(e);
    e.we = 1'b1; e.adr = A5_REG_FRAME;  e.dat = {10'b0, f};   bus_q.push_back(e);
    e.we = 1'b0; e.adr = A5_REG_LOAD;   e.dat = '0;           bus_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.we = 1'b0; e.adr = A5_REG_ID; e.dat = '0; bus_q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    rd_words.push_back(w);
    ks_q.push_back(w);
  endtask

  task automatic do_start(input logic [63:0] k, input logic [21:0] f, input logic [CNT_W-1:0] n);
    @(posedge clk); #1;
    key = k; frame = f; num_words = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    check(tag, 64'(done_cnt != d0), 1);
  endtask

  initial begin
    int d0, b0, a0, e0, r0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o}, '0);
    check("reset_dat", {32'h0, wbm_dat_o}, '0);
    check("reset_ctl", {busy, done, error, ks_valid, ks_data}, '0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: configure + load only
    last_rd_rise = -1; b0 = beats; d0 = done_cnt;
    begin
      bus_t e;
      e.we = 1'b1; e.adr = 32'h10; e.dat = 32'h89ABCDEF; bus_q.push_back(e);
      e.we = 1'b1; e.adr = 32'h14; e.dat = 32'h01234567; bus_q.push_back(e);
      e.we = 1'b1; e.adr = 32'h18; e.dat = 32'h002AAAAA; bus_q.push_back(e);
      e.we = 1'b0; e.adr = 32'h04; e.dat = 32'h0;        bus_q.push_back(e);
    end
    do_start(64'h0123456789ABCDEF, 22'h2AAAAA, '0);
    check("t1_busy_after_start", 64'(busy), 1);
    wait_done(1000, "t1_done_seen");
    check("t1_load_wait", 64'((done_cyc - load_ack_cyc >= int'(LOAD_WAIT)) &&
                              (done_cyc - load_ack_cyc <= int'(LOAD_WAIT) + 3)), 1);
    @(negedge clk);
    check("t1_busy_clear", 64'(busy), 0);
    check("t1_no_words", 64'(beats - b0), 0);
    check("t1_bus_drained", 64'(bus_q.size()), 0);

    // 2: three words, consumer always ready
    last_rd_rise = -1; b0 = beats; d0 = done_cnt;
    push_seq(64'hFEDCBA9876543210, 22'h000123, 3);
    push_word(32'h11111111); push_word(32'h22222222); push_word(32'h33333333);
    do_start(64'hFEDCBA9876543210, 22'h000123, 16'd3);
    wait_done(2000, "t2_done_seen");
    check("t2_first_read_after_load", 64'((first_rd_rise - load_ack_cyc > int'(LOAD_WAIT)) &&
                                          (first_rd_rise - load_ack_cyc <= int'(LOAD_WAIT) + 3)), 1);
    repeat (5) @(negedge clk);
    check("t2_beats", 64'(beats - b0), 3);
    check("t2_one_done", 64'(done_cnt - d0), 1);
    check("t2_ks_drained", 64'(ks_q.size()), 0);

    // 3: backpressure on the first of two words
    last_rd_rise = -1; b0 = beats;
    ks_ready = 1'b0;
    push_seq(64'h1, 22'h1, 2);
    push_word(32'hAAAA0001); push_word(32'hAAAA0002);
    do_start(64'h1, 22'h1, 16'd2);
    n = 0;
    while (!ks_valid && n < 1000) begin @(negedge clk); n++; end
    check("t3_valid_seen", 64'(ks_valid), 1);
    r0 = rd_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 64'(ks_valid), 1);
      check("t3_hold_data", 64'(ks_data), 64'h00000000AAAA0001);
      check("t3_no_read_while_stalled", 64'(rd_cnt - r0), 0);
    end
    @(posedge clk); #1 ks_ready = 1'b1;
    wait_done(1000, "t3_done_seen");
    repeat (3) @(negedge clk);
    check("t3_beats", 64'(beats - b0), 2);
    check("t3_ks_drained", 64'(ks_q.size()), 0);

    // 4: slave never acks the key-high write
    last_rd_rise = -1; d0 = done_cnt; e0 = err_cnt;
    s_block = 1'b1; s_block_adr = A5_REG_KEY_HI;
    begin
      bus_t e;
      e.we = 1'b1; e.adr = A5_REG_KEY_LO; e.dat = 32'hCAFEF00D; bus_q.push_back(e);
    end
    do_start({32'h12345678, 32'hCAFEF00D}, 22'h3, 16'd1);
    n = 0;
    while (err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
    check("t4_error_seen", 64'(err_cnt - e0), 1);
    check("t4_error_latency", 64'(err_cyc - last_stb_rise), 64'(ACK_TIMEOUT));
    check("t4_bus_idle", {wbm_cyc_o, wbm_stb_o, busy, ks_valid}, 0);
    repeat (30) @(negedge clk);
    check("t4_no_done", 64'(done_cnt - d0), 0);
    check("t4_single_error", 64'(err_cnt - e0), 1);
    check("t4_bus_drained", 64'(bus_q.size()), 0);
    s_block = 1'b0;

    // 5: start re-pulsed while busy
    last_rd_rise = -1; d0 = done_cnt; a0 = acc_cnt;
    push_seq(64'h0F0F0F0F_F0F0F0F0, 22'h155555, 1);
    push_word(32'h76543210);
    do_start(64'h0F0F0F0F_F0F0F0F0, 22'h155555, 16'd1);
    repeat (3) @(posedge clk);
    do_start(64'hFFFFFFFF_FFFFFFFF, 22'h3FFFFF, 16'd4);
    repeat (40) @(posedge clk);
    do_start(64'h0, 22'h0, 16'd7);
    wait_done(1000, "t5_done_seen");
    repeat (40) @(negedge clk);
    check("t5_access_count", 64'(acc_cnt - a0), 5);
    check("t5_one_done", 64'(done_cnt - d0), 1);
    check("t5_bus_drained", 64'(bus_q.size()), 0);

    // 6: reset during a keystream read with stb high
    last_rd_rise = -1;
    push_seq(64'h55, 22'h55, 1);
    push_word(32'h5A5A5A5A);
    do_start(64'h55, 22'h55, 16'd1);
    n = 0;
    while (!(wbm_stb_o && !wbm_we_o && wbm_adr_o == A5_REG_ID) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("t6_in_read", 64'(wbm_stb_o), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_drops", {wbm_cyc_o, wbm_stb_o, ks_valid, busy}, 0);
    bus_q.delete(); ks_q.delete(); rd_words.delete();
    @(posedge clk); #1 reset = 1'b0;
    last_rd_rise = -1; b0 = beats;
    push_seq(64'hA5A5A5A5_5A5A5A5A, 22'h0ABCDE, 1);
    push_word(32'hC3C3C3C3);
    do_start(64'hA5A5A5A5_5A5A5A5A, 22'h0ABCDE, 16'd1);
    wait_done(1000, "t6_done_after_reset");
    repeat (3) @(negedge clk);
    check("t6_beats", 64'(beats - b0), 1);
    check("t6_bus_drained", 64'(bus_q.size()), 0);
    check("t6_ks_drained", 64'(ks_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
